memory_core: RTL and testbench
==============================

MEMORY_CORE -- requirements
Module: memory_core

Interface
REQ-001 SHALL have parameter WIDTH, default 18, user word width in bits (1..256).
REQ-002 SHALL have parameter DEPTH, default 256, number of user words (>=2).
REQ-003 SHALL have parameter BASE_ADDR, default 0, first bus address owned by the core.
REQ-004 SHALL have port clk, input, 1, the single clock for bus and user sides.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have bus inputs addr_i (16), wdata_i (16), rdata_i (16), rw_i (1, 1=write), valid_i (1).
REQ-007 SHALL have registered bus outputs addr_o (16), wdata_o (16), rdata_o (16), rw_o (1), valid_o (1).
REQ-008 SHALL have user port addr, input, $clog2(DEPTH), word address.
REQ-009 SHALL have user port din, input, WIDTH, write data.
REQ-010 SHALL have user port dout, output, WIDTH, read data.
REQ-011 SHALL have user port we, input, 1, user write enable.

Function
REQ-012 SHALL set N_CHUNKS = ceil(WIDTH/16); chunk c holds word bits [16c+15:16c], with the last chunk holding WIDTH-16*(N_CHUNKS-1) bits.
REQ-013 SHALL map bus address a in [BASE_ADDR, BASE_ADDR+DEPTH*N_CHUNKS-1] to word (a-BASE_ADDR)/N_CHUNKS, chunk (a-BASE_ADDR)%N_CHUNKS; all other addresses are out of range.
REQ-014 SHALL forward every bus beat (valid_i high at edge k) to the outputs after edge k+3, with addr, wdata, rw, valid unchanged; no backpressure, one beat per cycle.
REQ-015 SHALL, for an in-range read, drive rdata_o with the chunk value, zero-extended to 16 bits; otherwise rdata_o = rdata_i of that beat.
REQ-016 SHALL, for an in-range write, commit wdata_i (truncated to chunk width) at edge k+1; rdata_o of that beat = rdata_i.
REQ-017 SHALL return, for a read accepted at edge k, data including all writes committed at or before edge k+1.
REQ-018 SHALL ignore out-of-range beats for memory purposes and forward them unchanged.
REQ-019 SHALL give the user port a 2-cycle read latency: addr sampled at edge k appears on dout after edge k+2; read-first (old data) on a same-cycle user write to that word.
REQ-020 SHALL, when bus and user writes commit to the same word on the same edge, store user data in all chunks and drop the bus write.
REQ-021 SHALL let back-to-back beats to any mix of addresses proceed at full rate with no bubbles.

Reset
REQ-022 SHALL, while rst is high at an edge, clear all pipeline valid bits and drive addr_o, wdata_o, rdata_o, rw_o, valid_o and dout to 0.
REQ-023 SHALL discard in-flight beats on reset; no valid_o is produced for beats accepted before reset.
REQ-024 SHALL suppress a bus write whose commit edge has rst high; memory contents are otherwise not cleared by reset.

Configuration
REQ-025 SHALL compile user write support only when MEMORY_CORE_USER_WRITE_EN is defined: din and we write the memory per REQ-019/REQ-020.
REQ-026 SHALL, without MEMORY_CORE_USER_WRITE_EN, ignore din and we (user port read-only) and omit the collision logic of REQ-020.

Verification (WIDTH=18, DEPTH=256, BASE_ADDR=0, macro defined unless noted)
REQ-027 SHALL cover: bus write addr 0x0004 data 0xBEEF, write 0x0005 data 0x0003; user reads addr 2 -> dout = 0x3BEEF two cycles later.
REQ-028 SHALL cover: user writes addr 7 din 0x2A5A5; bus reads 0x000E, 0x000F back-to-back -> rdata_o = 0xA5A5 then 0x0002, each 3 cycles after its beat.
REQ-029 SHALL cover: bus read 0x0200 (out of range) with rdata_i 0x1234 -> rdata_o = 0x1234, addr_o = 0x0200, memory unchanged.
REQ-030 SHALL cover: same-edge bus write 0x0010 data 0xFFFF and user write addr 8 din 0x00001 -> word 8 reads 0x00001.
REQ-031 SHALL cover: rst high one cycle after three reads issued -> no valid_o for those reads, all outputs 0 during reset.
REQ-032 SHALL cover, macro undefined: user write addr 3 din 0x11111 -> bus read of 0x0006 returns prior content 0x0000.

Source files
------------

// File: rtl/memory_core.sv
// memory_core: word-addressed RAM shared by a 16-bit pass-through bus and a user port.
// Bus beats flow through a fixed 3-cycle pipeline. In-range beats access one 16-bit chunk
// of a user word; all other beats are forwarded untouched.
// The user port reads with 2-cycle latency. Writes from the user port are built only
// when MEMORY_CORE_USER_WRITE_EN is defined.
module memory_core #(
  parameter int unsigned WIDTH     = 18,
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [15:0]              addr_i,
  input  logic [15:0]              wdata_i,
  input  logic [15:0]              rdata_i,
  input  logic                     rw_i,
  input  logic                     valid_i,
  output logic [15:0]              addr_o,
  output logic [15:0]              wdata_o,
  output logic [15:0]              rdata_o,
  output logic                     rw_o,
  output logic                     valid_o,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  input  logic                     we
);

  localparam int unsigned NChunks  = (WIDTH + 15) / 16;
  localparam int unsigned AW       = $clog2(DEPTH);
  localparam int unsigned CW       = (NChunks > 1) ? $clog2(NChunks) : 1;
  localparam int unsigned PadW     = 16 * NChunks;
  localparam int unsigned LastW    = WIDTH - 16 * (NChunks - 1);
  localparam int unsigned BusWords = DEPTH * NChunks;
  localparam logic [15:0] LastMask = 16'hFFFF >> (16 - LastW);

  typedef struct packed {
    logic          valid;
    logic          rw;
    logic          hit;
    logic [15:0]   addr;
    logic [15:0]   wdata;
    logic [15:0]   rdata;
    logic [AW-1:0] word;
    logic [CW-1:0] chunk;
  } beat_t;

  // Last stage no longer needs the memory coordinates.
  typedef struct packed {
    logic        valid;
    logic        rw;
    logic        hit;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
  } fwd_t;

  beat_t s1_d, s1_q, s2_d, s2_q;
  fwd_t  s3_d, s3_q;
  logic [15:0] s3_rd_d, s3_rd_q;
  logic [15:0] addr_d, addr_q, wdata_d, wdata_q, rdata_d, rdata_q;
  logic        rw_d, rw_q, valid_d, valid_q;
  logic [WIDTH-1:0] ud1_d, ud1_q, ud2_d, ud2_q, dout_d, dout_q;

  logic [15:0] mem_q [DEPTH][NChunks];

  logic [32:0]   bus_diff;
  logic          bus_hit;
  logic [AW-1:0] bus_word;
  logic [CW-1:0] bus_chunk;
  logic          bus_we;
  logic [15:0]   bus_wmask;
  logic [PadW-1:0] ur_word;
  logic          unused_pad;

  // Bus address decode; the extra top bit of the difference flags addresses below the base.
  always_comb begin
    bus_diff  = {17'b0, addr_i} - 33'(BASE_ADDR);
    bus_hit   = !bus_diff[32] && (bus_diff[31:0] < BusWords);
    bus_word  = '0;
    bus_chunk = '0;
    if (bus_hit) begin
      bus_word  = AW'(bus_diff[31:0] / NChunks);
      bus_chunk = CW'(bus_diff[31:0] % NChunks);
    end
  end

  // Bus pipeline next state: capture, hold for write commit, then memory read.
  always_comb begin
    s1_d       = '0;
    s1_d.valid = valid_i;
    s1_d.rw    = rw_i;
    s1_d.hit   = bus_hit;
    s1_d.addr  = addr_i;
    s1_d.wdata = wdata_i;
    s1_d.rdata = rdata_i;
    s1_d.word  = bus_word;
    s1_d.chunk = bus_chunk;
    s2_d       = s1_q;
    s3_d.valid = s2_q.valid;
    s3_d.rw    = s2_q.rw;
    s3_d.hit   = s2_q.hit;
    s3_d.addr  = s2_q.addr;
    s3_d.wdata = s2_q.wdata;
    s3_d.rdata = s2_q.rdata;
    // Read one edge after commit so a read sees writes committed up to its own k+1.
    s3_rd_d    = mem_q[s2_q.word][s2_q.chunk];
  end

  // Output register next state; in-range reads replace the bus read data.
  always_comb begin
    addr_d  = s3_q.addr;
    wdata_d = s3_q.wdata;
    rw_d    = s3_q.rw;
    valid_d = s3_q.valid;
    rdata_d = (s3_q.hit && !s3_q.rw) ? s3_rd_q : s3_q.rdata;
  end

`ifdef MEMORY_CORE_USER_WRITE_EN
  logic            user_we;
  logic [PadW-1:0] din_pad;

  // Bus write commit; a same-edge user write to the same word wins outright.
  always_comb begin
    user_we   = we;
    din_pad   = PadW'(din);
    bus_we    = s1_q.valid && s1_q.rw && s1_q.hit && !rst;
    if (user_we && (addr == s1_q.word)) begin
      bus_we = 1'b0;
    end
    bus_wmask = (s1_q.chunk == CW'(NChunks - 1)) ? LastMask : 16'hFFFF;
  end

  // Memory array (not reset): bus chunk write plus whole-word user write.
  always_ff @(posedge clk) begin
    if (bus_we) begin
      mem_q[s1_q.word][s1_q.chunk] <= s1_q.wdata & bus_wmask;
    end
    if (user_we) begin
      for (int c = 0; c < NChunks; c++) begin
        mem_q[addr][CW'(c)] <= din_pad[16*c +: 16];
      end
    end
  end
`else
  logic unused_user;
  assign unused_user = ^{din, we};

  // Bus write commit; user port is read-only.
  always_comb begin
    bus_we    = s1_q.valid && s1_q.rw && s1_q.hit && !rst;
    bus_wmask = (s1_q.chunk == CW'(NChunks - 1)) ? LastMask : 16'hFFFF;
  end

  // Memory array (not reset): bus chunk write only.
  always_ff @(posedge clk) begin
    if (bus_we) begin
      mem_q[s1_q.word][s1_q.chunk] <= s1_q.wdata & bus_wmask;
    end
  end
`endif

  // User read path: sample old contents at the address edge (read-first), then two stages.
  always_comb begin
    ur_word = '0;
    for (int c = 0; c < NChunks; c++) begin
      ur_word[16*c +: 16] = mem_q[addr][CW'(c)];
    end
    ud1_d  = ur_word[WIDTH-1:0];
    ud2_d  = ud1_q;
    dout_d = ud2_q;
  end
  assign unused_pad = ^ur_word;

  // Pipeline and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= '0;
      s2_q    <= '0;
      s3_q    <= '0;
      s3_rd_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rw_q    <= 1'b0;
      valid_q <= 1'b0;
      ud1_q   <= '0;
      ud2_q   <= '0;
      dout_q  <= '0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      s3_q    <= s3_d;
      s3_rd_q <= s3_rd_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      rw_q    <= rw_d;
      valid_q <= valid_d;
      ud1_q   <= ud1_d;
      ud2_q   <= ud2_d;
      dout_q  <= dout_d;
    end
  end

  assign addr_o  = addr_q;
  assign wdata_o = wdata_q;
  assign rdata_o = rdata_q;
  assign rw_o    = rw_q;
  assign valid_o = valid_q;
  assign dout    = dout_q;

endmodule

// File: tb/tb_memory_core.sv
// Directed self-checking bench for memory_core (WIDTH=18, DEPTH=256, BASE_ADDR=0).
// Expected values that depend on user writes follow MEMORY_CORE_USER_WRITE_EN.
module tb_memory_core;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr_i, wdata_i, rdata_i;
  logic        rw_i, valid_i;
  logic [15:0] addr_o, wdata_o, rdata_o;
  logic        rw_o, valid_o;
  logic [7:0]  addr;
  logic [17:0] din;
  logic [17:0] dout;
  logic        we;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef MEMORY_CORE_USER_WRITE_EN
  localparam bit UserWr = 1'b1;
`else
  localparam bit UserWr = 1'b0;
`endif

  memory_core #(
    .WIDTH    (18),
    .DEPTH    (256),
    .BASE_ADDR(0)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .addr_i (addr_i),
    .wdata_i(wdata_i),
    .rdata_i(rdata_i),
    .rw_i   (rw_i),
    .valid_i(valid_i),
    .addr_o (addr_o),
    .wdata_o(wdata_o),
    .rdata_o(rdata_o),
    .rw_o   (rw_o),
    .valid_o(valid_o),
    .addr   (addr),
    .din    (din),
    .dout   (dout),
    .we     (we)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [15:0] a, input logic [15:0] w, input logic [15:0] r,
                      input logic rw);
    addr_i  = a;
    wdata_i = w;
    rdata_i = r;
    rw_i    = rw;
    valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
  endtask

  task automatic idle();
    valid_i = 1'b0;
    tick();
  endtask

  // Single isolated read: outputs appear after the third edge following acceptance.
  task automatic bus_read(input logic [15:0] a, input logic [15:0] r, input logic [15:0] exp,
                          input string tag);
    beat(a, 16'h0000, r, 1'b0);
    idle();
    idle();
    idle();
    check_eq({tag, "_rdata"}, 32'(rdata_o), 32'(exp));
    check_eq({tag, "_addr"}, 32'(addr_o), 32'(a));
    check_eq({tag, "_valid"}, 32'(valid_o), 32'd1);
  endtask

  logic [15:0] seeds [7];

  initial begin
    #100000;
    $display("FAIL timeout: got no end of test, expected completion");
    $fatal(1);
  end

  initial begin
    seeds = '{16'h0000, 16'h0006, 16'h0007, 16'h000C, 16'h000E, 16'h000F, 16'h0011};
    rst = 1'b1; addr_i = '0; wdata_i = '0; rdata_i = '0; rw_i = 1'b0; valid_i = 1'b0;
    addr = '0; din = '0; we = 1'b0;
    tick();
    tick();
    check_eq("rst_valid_o", 32'(valid_o), 32'd0);
    check_eq("rst_addr_o", 32'(addr_o), 32'd0);
    check_eq("rst_rdata_o", 32'(rdata_o), 32'd0);
    check_eq("rst_dout", 32'(dout), 32'd0);
    rst = 1'b0;

    // Zero a handful of chunks back-to-back; forwarding must keep pace with no bubbles.
    for (int i = 0; i < 10; i++) begin
      if (i < 7) beat(seeds[i], 16'h0000, 16'h5550 + 16'(i), 1'b1);
      else idle();
      if (i >= 3) begin
        check_eq("seed_fwd_addr", 32'(addr_o), 32'(seeds[i-3]));
        check_eq("seed_fwd_rdata", 32'(rdata_o), 32'h5550 + 32'(i - 3));
        check_eq("seed_fwd_valid", 32'(valid_o), 32'd1);
        check_eq("seed_fwd_rw", 32'(rw_o), 32'd1);
      end
    end
    idle();
    check_eq("seed_drain_valid", 32'(valid_o), 32'd0);

    // Two bus writes build word 2, then the user port reads it.
    beat(16'h0004, 16'hBEEF, 16'h0000, 1'b1);
    beat(16'h0005, 16'h0003, 16'h0000, 1'b1);
    idle();
    addr = 8'd2;
    idle();
    check_eq("w2_fwd_addr", 32'(addr_o), 32'h0004);
    check_eq("w2_fwd_wdata", 32'(wdata_o), 32'hBEEF);
    idle();
    check_eq("w2_fwd_addr2", 32'(addr_o), 32'h0005);
    idle();
    check_eq("w2_user_dout", 32'(dout), 32'h3BEEF);
    bus_read(16'h0005, 16'hFFFF, 16'h0003, "w2_chunk1");

    // User write to word 3 is visible on the bus only when user writes are built.
    addr = 8'd3; din = 18'h11111; we = 1'b1;
    idle();
    we = 1'b0;
    bus_read(16'h0006, 16'h4444, UserWr ? 16'h1111 : 16'h0000, "w3_chunk0");
    bus_read(16'h0007, 16'h4444, UserWr ? 16'h0001 : 16'h0000, "w3_chunk1");

    // User write to word 7 with read-first on the same edge, then back-to-back bus reads.
    addr = 8'd7; din = 18'h2A5A5; we = 1'b1;
    idle();
    we = 1'b0;
    beat(16'h000E, 16'h0000, 16'h1111, 1'b0);
    beat(16'h000F, 16'h0000, 16'h2222, 1'b0);
    check_eq("w7_read_first", 32'(dout), 32'd0);
    idle();
    check_eq("w7_user_dout", 32'(dout), UserWr ? 32'h2A5A5 : 32'd0);
    idle();
    check_eq("w7_bus_rd0", 32'(rdata_o), UserWr ? 32'hA5A5 : 32'd0);
    check_eq("w7_bus_rd0_valid", 32'(valid_o), 32'd1);
    idle();
    check_eq("w7_bus_rd1", 32'(rdata_o), UserWr ? 32'h0002 : 32'd0);
    check_eq("w7_bus_rd1_addr", 32'(addr_o), 32'h000F);

    // Range boundaries: last chunk truncates, first out-of-range address passes through.
    beat(16'h01FF, 16'hFFFF, 16'h0000, 1'b1);
    idle();
    bus_read(16'h01FF, 16'hABCD, 16'h0003, "last_chunk");
    bus_read(16'h0200, 16'h1234, 16'h1234, "oor_read");
    beat(16'h0200, 16'hAAAA, 16'h0000, 1'b1);
    idle();
    bus_read(16'h0000, 16'h9999, 16'h0000, "oor_no_alias");

    // Same-edge bus and user writes to word 8.
    beat(16'h0010, 16'hFFFF, 16'h0000, 1'b1);
    addr = 8'd8; din = 18'h00001; we = 1'b1;
    idle();
    we = 1'b0;
    bus_read(16'h0010, 16'h0000, UserWr ? 16'h0001 : 16'hFFFF, "collide_c0");
    bus_read(16'h0011, 16'h0000, 16'h0000, "collide_c1");
    check_eq("collide_dout", 32'(dout), UserWr ? 32'h00001 : 32'h0FFFF);

    // Reset with beats in flight; the pending write to 0x000C must not land.
    beat(16'h0000, 16'h0000, 16'hAAAA, 1'b0);
    beat(16'h0006, 16'h0000, 16'hBBBB, 1'b0);
    beat(16'h000C, 16'h7777, 16'hCCCC, 1'b1);
    rst = 1'b1;
    tick();
    check_eq("inrst_valid_o", 32'(valid_o), 32'd0);
    check_eq("inrst_addr_o", 32'(addr_o), 32'd0);
    check_eq("inrst_wdata_o", 32'(wdata_o), 32'd0);
    check_eq("inrst_rdata_o", 32'(rdata_o), 32'd0);
    check_eq("inrst_rw_o", 32'(rw_o), 32'd0);
    check_eq("inrst_dout", 32'(dout), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idle();
      check_eq("postrst_no_valid", 32'(valid_o), 32'd0);
    end
    bus_read(16'h000C, 16'h0000, 16'h0000, "rst_write_dropped");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
